spi_master: RTL and testbench

//  SPI bus master that sits directly upstream of spi_slave and drives its sclk, cs and mosi pins.

---
 rtl/spi_pkg.sv | 21 ++
 rtl/spi_master_if.sv | 26 ++
 rtl/spi_clk_div.sv | 30 +++
 rtl/spi_master.sv | 153 +++++++++++++++
 tb/tb_spi_master.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// Shared types, default sizes and helpers for the SPI master.
package spi_pkg;

   localparam int unsigned SPI_DATA_W  = 8;
   localparam int unsigned SPI_CLK_DIV = 4;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      HIGH,
      LOW,
      HOLD,
      DONE
   } spi_state_e;

   // Counter width able to hold 0..n-1; never narrower than one bit.
   function automatic int unsigned cnt_w(input int unsigned n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/spi_master_if.sv
// Parallel request/response and serial pin bundle between a host and the SPI master.
interface spi_master_if
   import spi_pkg::*;
#(
   parameter int unsigned DATA_W = SPI_DATA_W
);
   logic              start;
   logic [DATA_W-1:0] tx_data;
   logic [DATA_W-1:0] rx_data;
   logic              busy;
   logic              done;
   logic              sclk;
   logic              cs;
   logic              mosi;
   logic              miso;

   modport master (
      input  start, tx_data, miso,
      output rx_data, busy, done, sclk, cs, mosi
   );

   modport slave (
      output start, tx_data, miso,
      input  rx_data, busy, done, sclk, cs, mosi
   );
endinterface

// File: rtl/spi_clk_div.sv
// Half-period divider: pulses tick on the last of every CLK_DIV enabled cycles.
module spi_clk_div
   import spi_pkg::*;
#(
   parameter int unsigned CLK_DIV = SPI_CLK_DIV
) (
   input  logic clk,
   input  logic reset,
   input  logic en,
   input  logic clr,
   output logic tick
);
   localparam int unsigned    CW   = cnt_w(CLK_DIV);
   localparam logic [CW-1:0]  TERM = CW'(CLK_DIV - 1);

   logic [CW-1:0] r_cnt;

   assign tick = en && (r_cnt == TERM);

   // Count while enabled, wrap on terminal count; clear has priority.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_cnt <= '0;
      end else if (clr) begin
         r_cnt <= '0;
      end else if (en) begin
         r_cnt <= tick ? '0 : r_cnt + CW'(1);
      end
   end
endmodule

// File: rtl/spi_master.sv
// Mode-0 SPI master: one LSB-first frame per accepted start, registered outputs only.
module spi_master
   import spi_pkg::*;
#(
   parameter int unsigned DATA_W  = SPI_DATA_W,
   parameter int unsigned CLK_DIV = SPI_CLK_DIV
) (
   input  logic         clk,
   input  logic         reset,
   spi_master_if.master bus
);
   localparam int unsigned   BW   = cnt_w(DATA_W);
   localparam logic [BW-1:0] LAST = BW'(DATA_W - 1);

   spi_state_e        r_state, w_state;
   logic [DATA_W-1:0] r_tx_sr, w_tx_sr;
   logic [DATA_W-1:0] r_rx_sr, w_rx_sr;
   logic [DATA_W-1:0] r_rx_data, w_rx_data;
   logic [BW-1:0]     r_bit_cnt, w_bit_cnt;
   logic              r_sclk, w_sclk;
   logic              r_cs, w_cs;
   logic              r_mosi, w_mosi;
   logic              r_busy, w_busy;
   logic              r_done, w_done;
   logic              w_tick;
   logic              w_en;
   logic              w_clr;

   // Divider runs outside IDLE and is held at zero while idle, so SETUP starts from 0.
   assign w_en  = (r_state != IDLE);
   assign w_clr = (r_state == IDLE);

   spi_clk_div #(
      .CLK_DIV (CLK_DIV)
   ) u_clk_div (
      .clk   (clk),
      .reset (reset),
      .en    (w_en),
      .clr   (w_clr),
      .tick  (w_tick)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state;
      end
   end

   // Next-state and next datapath/output values.
   always_comb begin
      w_state   = r_state;
      w_tx_sr   = r_tx_sr;
      w_rx_sr   = r_rx_sr;
      w_rx_data = r_rx_data;
      w_bit_cnt = r_bit_cnt;
      w_sclk    = r_sclk;
      w_cs      = r_cs;
      w_mosi    = r_mosi;
      w_busy    = r_busy;
      w_done    = r_done;

      case (r_state)
         IDLE: begin
            if (bus.start) begin
               w_tx_sr   = bus.tx_data;
               w_bit_cnt = '0;
               w_cs      = 1'b0;
               w_mosi    = bus.tx_data[0];
               w_busy    = 1'b1;
               w_state   = SETUP;
            end
         end
         SETUP: begin
            if (w_tick) begin
               w_sclk  = 1'b1;
               w_state = HIGH;
            end
         end
         HIGH: begin
            // miso is captured at the end of the sclk-high phase.
            if (w_tick) begin
               w_rx_sr = {bus.miso, r_rx_sr[DATA_W-1:1]};
               w_sclk  = 1'b0;
               w_state = LOW;
            end
         end
         LOW: begin
            if (w_tick) begin
               if (r_bit_cnt == LAST) begin
                  w_state = HOLD;
               end else begin
                  w_bit_cnt = r_bit_cnt + BW'(1);
                  w_tx_sr   = r_tx_sr >> 1;
                  w_mosi    = r_tx_sr[1];
                  w_sclk    = 1'b1;
                  w_state   = HIGH;
               end
            end
         end
         HOLD: begin
            if (w_tick) begin
               w_cs      = 1'b1;
               w_rx_data = r_rx_sr;
               w_done    = 1'b1;
               w_state   = DONE;
            end
         end
         DONE: begin
            w_done  = 1'b0;
            w_busy  = 1'b0;
            w_state = IDLE;
         end
         default: begin
            w_state = IDLE;
         end
      endcase
   end

   // Datapath and output registers.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_tx_sr   <= '0;
         r_rx_sr   <= '0;
         r_rx_data <= '0;
         r_bit_cnt <= '0;
         r_sclk    <= 1'b0;
         r_cs      <= 1'b1;
         r_mosi    <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_tx_sr   <= w_tx_sr;
         r_rx_sr   <= w_rx_sr;
         r_rx_data <= w_rx_data;
         r_bit_cnt <= w_bit_cnt;
         r_sclk    <= w_sclk;
         r_cs      <= w_cs;
         r_mosi    <= w_mosi;
         r_busy    <= w_busy;
         r_done    <= w_done;
      end
   end

   assign bus.rx_data = r_rx_data;
   assign bus.busy    = r_busy;
   assign bus.done    = r_done;
   assign bus.sclk    = r_sclk;
   assign bus.cs      = r_cs;
   assign bus.mosi    = r_mosi;
endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: loopback, slave model, busy-start, reset abort, CLK_DIV=1 streaming.
module tb_spi_master;
   import spi_pkg::*;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   spi_master_if #(.DATA_W(8)) bus1 ();
   spi_master_if #(.DATA_W(8)) bus2 ();

   // Loopback or behavioural mode-0 slave on the CLK_DIV=4 instance; pure loopback on CLK_DIV=1.
   logic       loop1  = 1'b1;
   logic       s_miso = 1'b0;
   logic [7:0] s_load = 8'h00;
   logic [7:0] s_out  = 8'h00;
   logic [7:0] s_in   = 8'h00;
   int         rises  = 0;
   int         falls  = 0;

   assign bus1.miso = loop1 ? bus1.mosi : s_miso;
   assign bus2.miso = bus2.mosi;

   spi_master #(.DATA_W(8), .CLK_DIV(4)) u_dut1 (.clk(clk), .reset(reset), .bus(bus1));
   spi_master #(.DATA_W(8), .CLK_DIV(1)) u_dut2 (.clk(clk), .reset(reset), .bus(bus2));

   // Slave: present first bit on cs fall, sample mosi on rise, shift out on fall.
   always @(negedge bus1.cs) begin
      s_out  = s_load;
      s_miso = s_load[0];
   end

   always @(posedge bus1.sclk) begin
      s_in  = {bus1.mosi, s_in[7:1]};
      rises = rises + 1;
   end

   always @(negedge bus1.sclk) begin
      s_out  = s_out >> 1;
      s_miso = s_out[0];
      falls  = falls + 1;
   end

   // Continuous protocol checks, sampled away from the active edge.
   logic p_sclk   = 1'b0;
   logic p_mosi   = 1'b0;
   logic p_done   = 1'b0;
   int   done_cnt = 0;

   always @(negedge clk) begin
      if (p_sclk && bus1.sclk) begin
         total = total + 1;
         assert (bus1.mosi === p_mosi) else begin
            bad = bad + 1;
            $error("FAIL mosi_stable obs=%b exp=%b", bus1.mosi, p_mosi);
         end
      end
      total = total + 1;
      assert ((bus1.cs & bus1.sclk) === 1'b0) else begin
         bad = bad + 1;
         $error("FAIL sclk_idle1 obs=%b exp=0", bus1.cs & bus1.sclk);
      end
      total = total + 1;
      assert ((bus2.cs & bus2.sclk) === 1'b0) else begin
         bad = bad + 1;
         $error("FAIL sclk_idle2 obs=%b exp=0", bus2.cs & bus2.sclk);
      end
      if (bus1.done) begin
         done_cnt = done_cnt + 1;
         total = total + 1;
         assert (bus1.busy === 1'b1) else begin
            bad = bad + 1;
            $error("FAIL done_busy obs=%b exp=1", bus1.busy);
         end
      end
      if (p_done) begin
         total = total + 1;
         assert (bus1.done === 1'b0) else begin
            bad = bad + 1;
            $error("FAIL done_pulse obs=%b exp=0", bus1.done);
         end
      end
      p_sclk = bus1.sclk;
      p_mosi = bus1.mosi;
      p_done = bus1.done;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total = total + 1;
      assert (obs === exp) else begin
         bad = bad + 1;
         $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   // One-cycle start on instance 1; tx_data is scrambled after acceptance. lat=-1 on timeout.
   task automatic start_frame(input logic [7:0] d, output int lat);
      bus1.tx_data = d;
      bus1.start   = 1'b1;
      lat = -1;
      for (int i = 1; i <= 200; i++) begin
         @(negedge clk);
         if (i == 1) begin
            bus1.start   = 1'b0;
            bus1.tx_data = ~d;
         end
         if (bus1.done) begin
            lat = i;
            break;
         end
      end
   endtask

   initial begin
      int lat;
      bus1.start   = 1'b0;
      bus1.tx_data = 8'h00;
      bus2.start   = 1'b0;
      bus2.tx_data = 8'h00;

      // Reset values
      repeat (3) @(negedge clk);
      chk("rst_sclk", 32'(bus1.sclk), 32'd0);
      chk("rst_cs",   32'(bus1.cs),   32'd1);
      chk("rst_mosi", 32'(bus1.mosi), 32'd0);
      chk("rst_busy", 32'(bus1.busy), 32'd0);
      chk("rst_done", 32'(bus1.done), 32'd0);
      chk("rst_rx",   32'(bus1.rx_data), 32'd0);
      chk("rst_cs2",  32'(bus2.cs),   32'd1);
      reset = 1'b1;
      @(negedge clk);

      // Loopback A5
      loop1 = 1'b1;
      s_in  = 8'h00;
      rises = 0;
      falls = 0;
      start_frame(8'hA5, lat);
      chk("t1_latency", 32'(lat), 32'd73);
      chk("t1_rx",      32'(bus1.rx_data), 32'hA5);
      chk("t1_mosi_bits", 32'(s_in), 32'hA5);
      chk("t1_rises",   32'(rises), 32'd8);
      chk("t1_falls",   32'(falls), 32'd8);
      chk("t1_busy_done", 32'(bus1.busy), 32'd1);
      @(negedge clk);
      chk("t1_busy_after", 32'(bus1.busy), 32'd0);
      chk("t1_done_after", 32'(bus1.done), 32'd0);
      chk("t1_cs_after",   32'(bus1.cs),   32'd1);

      // Slave model exchange: master sends C3, slave returns 3C
      loop1  = 1'b0;
      s_load = 8'h3C;
      s_in   = 8'h00;
      start_frame(8'hC3, lat);
      chk("t2_latency", 32'(lat), 32'd73);
      chk("t2_rx",      32'(bus1.rx_data), 32'h3C);
      chk("t2_slave_rx", 32'(s_in), 32'hC3);
      chk("t2_cs_done", 32'(bus1.cs), 32'd1);
      @(negedge clk);
      chk("t2_cs_after", 32'(bus1.cs), 32'd1);

      // Start while busy is ignored
      loop1    = 1'b1;
      done_cnt = 0;
      bus1.tx_data = 8'h81;
      bus1.start   = 1'b1;
      for (int i = 1; i <= 120; i++) begin
         @(negedge clk);
         if (i == 1)  bus1.start = 1'b0;
         if (i == 30) begin
            chk("t3_busy_mid", 32'(bus1.busy), 32'd1);
            bus1.tx_data = 8'h7E;
            bus1.start   = 1'b1;
         end
         if (i == 31) bus1.start = 1'b0;
      end
      chk("t3_done_count", 32'(done_cnt), 32'd1);
      chk("t3_rx", 32'(bus1.rx_data), 32'h81);

      // Reset mid-frame
      bus1.tx_data = 8'h3F;
      bus1.start   = 1'b1;
      @(negedge clk);
      bus1.start = 1'b0;
      repeat (29) @(negedge clk);
      chk("t4_busy_pre", 32'(bus1.busy), 32'd1);
      reset = 1'b0;
      @(negedge clk);
      chk("t4_cs",   32'(bus1.cs),   32'd1);
      chk("t4_sclk", 32'(bus1.sclk), 32'd0);
      chk("t4_busy", 32'(bus1.busy), 32'd0);
      chk("t4_rx",   32'(bus1.rx_data), 32'd0);
      chk("t4_mosi", 32'(bus1.mosi), 32'd0);
      reset    = 1'b1;
      done_cnt = 0;
      repeat (100) @(negedge clk);
      chk("t4_no_done", 32'(done_cnt), 32'd0);
      start_frame(8'h5A, lat);
      chk("t4_latency", 32'(lat), 32'd73);
      chk("t4_rx_after", 32'(bus1.rx_data), 32'h5A);
      @(negedge clk);

      // CLK_DIV=1, start held: done every 20 cycles, one idle cycle between frames
      bus2.tx_data = 8'h96;
      bus2.start   = 1'b1;
      for (int i = 1; i <= 60; i++) begin
         @(negedge clk);
         chk($sformatf("t5_done_c%0d", i), 32'(bus2.done), 32'((i % 20) == 19));
         chk($sformatf("t5_busy_c%0d", i), 32'(bus2.busy), 32'((i % 20) != 0));
         if (i == 60) bus2.start = 1'b0;
      end
      chk("t5_rx", 32'(bus2.rx_data), 32'h96);
      for (int i = 1; i <= 30; i++) begin
         @(negedge clk);
         chk("t5_quiet_done", 32'(bus2.done), 32'd0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
